// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU; add/sub/and/or/slt in one cycle, shift-add multiply over WIDTH cycles.
//   clk, rst_n (sync, active-low); in_valid/in_ready + op1, op2, aluCtrl command side;
//   out_valid/out_ready + result, zero, ovf, err registered result side.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       aluCtrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt, sum, diff, alu_r;
  logic alu_o, alu_e, mul_z, accept, last;
  assign accept = state == IDLE && in_valid;
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign sum = op1 + op2;
  assign diff = op1 - op2;
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = aluCtrl == 3'b001 ? MUL : DONE;
      MUL: if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    alu_r = '0;
    alu_o = 1'b0;
    alu_e = 1'b0;
    case (aluCtrl)
      3'b000: begin
        alu_r = sum;
        alu_o = op1[WIDTH-1] == op2[WIDTH-1] && sum[WIDTH-1] != op1[WIDTH-1];
      end
      3'b010: begin
        alu_r = diff;
        alu_o = op1[WIDTH-1] != op2[WIDTH-1] && diff[WIDTH-1] != op1[WIDTH-1];
      end
      3'b001: alu_r = '0;
      3'b011: alu_r = op1 & op2;
      3'b100: alu_r = op1 | op2;
      3'b101: alu_r = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      default: alu_e = 1'b1;
    endcase
  end
  // Multiply flags are parked in mul_z so visible outputs move only on the MUL->DONE edge.
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      mul_z <= 1'b0;
      result <= '0;
      zero <= 1'b0;
      ovf <= 1'b0;
      err <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      mcand <= op1;
      mplier <= op2;
      acc <= '0;
      mul_z <= op1 == op2;
      if (aluCtrl != 3'b001) begin
        result <= alu_r;
        zero <= op1 == op2;
        ovf <= alu_o;
        err <= alu_e;
      end
    end else if (state == MUL) begin
      acc <= acc_nxt;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= last ? '0 : cnt + CNT_W'(1);
      if (last) begin
        result <= acc_nxt;
        zero <= mul_z;
        ovf <= 1'b0;
        err <= 1'b0;
      end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: scoreboard bench for 32-bit and 8-bit multicycle_alu instances.
module tb_multicycle_alu;
  logic clk = 0, rst_n = 0, v = 0, ordy = 0, sel = 0;
  logic [31:0] a = 0, b = 0;
  logic [2:0] c = 0;
  logic ir32, ov32, z32, o32, e32, ir8, ov8, z8, o8, e8;
  logic [31:0] r32;
  logic [7:0] r8;
  logic ir, ov, z, o, e;
  logic [31:0] r;
  int checks = 0, errors = 0;
  typedef struct packed {logic [63:0] r; logic z, o, e;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  multicycle_alu u32 (.clk(clk), .rst_n(rst_n), .in_valid(v & !sel), .in_ready(ir32),
    .op1(a), .op2(b), .aluCtrl(c), .out_valid(ov32), .out_ready(ordy & !sel),
    .result(r32), .zero(z32), .ovf(o32), .err(e32));
  multicycle_alu #(.WIDTH(8), .CNT_W(4)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(v & sel),
    .in_ready(ir8), .op1(a[7:0]), .op2(b[7:0]), .aluCtrl(c), .out_valid(ov8),
    .out_ready(ordy & sel), .result(r8), .zero(z8), .ovf(o8), .err(e8));

  assign ir = sel ? ir8 : ir32;
  assign ov = sel ? ov8 : ov32;
  assign z = sel ? z8 : z32;
  assign o = sel ? o8 : o32;
  assign e = sel ? e8 : e32;
  assign r = sel ? {24'd0, r8} : r32;

  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y, input logic [2:0] op);
    exp_t t;
    logic [63:0] m, sx, sy;
    int s;
    m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    s = w - 1;
    x = x & m;
    y = y & m;
    sx = x[s] ? (x | ~m) : x;
    sy = y[s] ? (y | ~m) : y;
    t = '0;
    t.z = x == y;
    case (op)
      3'd0: begin t.r = (x + y) & m; t.o = x[s] == y[s] && t.r[s] != x[s]; end
      3'd2: begin t.r = (x - y) & m; t.o = x[s] != y[s] && t.r[s] != x[s]; end
      3'd1: t.r = (x * y) & m;
      3'd3: t.r = x & y;
      3'd4: t.r = x | y;
      3'd5: t.r = {63'd0, $signed(sx) < $signed(sy)};
      default: t.e = 1'b1;
    endcase
    return t;
  endfunction

  task automatic run(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op, input int hold,
                     input string nm, output logic [31:0] rr, output logic zz, output logic oo, output logic ee);
    int w, lat;
    exp_t ex;
    w = sel ? 8 : 32;
    lat = 1;
    @(negedge clk);
    checks++;
    if (ir !== 1'b1) begin errors++; $display("FAIL %s ready_before_accept got %b want 1", nm, ir); end
    a = x; b = y; c = op; v = 1; ordy = 0;
    q.push_back(model(w, {32'd0, x}, {32'd0, y}, op));
    @(negedge clk);
    v = 0; a = $urandom; b = $urandom;
    while (!ov && lat < 200) begin
      checks++;
      if (ir !== 1'b0) begin errors++; $display("FAIL %s ready_while_busy got %b want 0", nm, ir); end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != ((op == 3'b001) ? w + 1 : 1)) begin
      errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, (op == 3'b001) ? w + 1 : 1);
    end
    ex = q[0];
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (r !== ex.r[31:0] || z !== ex.z || o !== ex.o || e !== ex.e || ov !== 1'b1 || ir !== 1'b0) begin
        errors++; $display("FAIL %s hold%0d got r=%h z=%b o=%b e=%b v=%b rdy=%b want r=%h z=%b o=%b e=%b v=1 rdy=0",
                           nm, i, r, z, o, e, ov, ir, ex.r[31:0], ex.z, ex.o, ex.e);
      end
      v = 1'($urandom_range(0, 1)); c = 3'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
    end
    v = 1; ordy = 1; c = 3'($urandom); a = $urandom; b = $urandom;
    ex = q.pop_front();
    checks++;
    if (r !== ex.r[31:0] || z !== ex.z || o !== ex.o || e !== ex.e || ov !== 1'b1) begin
      errors++; $display("FAIL %s result got r=%h z=%b o=%b e=%b v=%b want r=%h z=%b o=%b e=%b v=1",
                         nm, r, z, o, e, ov, ex.r[31:0], ex.z, ex.o, ex.e);
    end
    rr = r; zz = z; oo = o; ee = e;
    @(negedge clk);
    v = 0; ordy = 0;
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      errors++; $display("FAIL %s release got v=%b rdy=%b want v=0 rdy=1", nm, ov, ir);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; v = 1; ordy = 1; c = 3'd0; a = 32'd7; b = 32'd9;
    repeat (3) @(negedge clk);
    checks++;
    if (ov32 !== 0 || r32 !== 0 || z32 !== 0 || o32 !== 0 || e32 !== 0 || ov8 !== 0 || r8 !== 0) begin
      errors++; $display("FAIL reset_outputs got v=%b r=%h z=%b o=%b e=%b v8=%b r8=%h want zeros", ov32, r32, z32, o32, e32, ov8, r8);
    end
    v = 0; ordy = 0; rst_n = 1;
    @(negedge clk);
    checks++;
    if (ir32 !== 1'b1 || ir8 !== 1'b1 || ov32 !== 1'b0) begin
      errors++; $display("FAIL reset_release got rdy=%b rdy8=%b v=%b want 1 1 0", ir32, ir8, ov32);
    end
  endtask

  task automatic test_add_ovf();
    logic [31:0] rr; logic zz, oo, ee;
    run(32'h7FFFFFFF, 32'h00000001, 3'b000, 0, "add_ovf", rr, zz, oo, ee);
    checks++;
    if (rr !== 32'h80000000 || oo !== 1 || zz !== 0 || ee !== 0) begin
      errors++; $display("FAIL add_ovf_const got r=%h o=%b z=%b e=%b want 80000000 1 0 0", rr, oo, zz, ee);
    end
    run(32'hFFFFFFFF, 32'h00000001, 3'b000, 1, "add_wrap", rr, zz, oo, ee);
    run(32'h80000000, 32'h00000001, 3'b010, 0, "sub_ovf", rr, zz, oo, ee);
  endtask

  task automatic test_mul();
    logic [31:0] rr; logic zz, oo, ee;
    run(32'h00010003, 32'h00010005, 3'b001, 0, "mul", rr, zz, oo, ee);
    checks++;
    if (rr !== 32'h0008000F) begin errors++; $display("FAIL mul_const got %h want 0008000f", rr); end
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 2, "mul_max", rr, zz, oo, ee);
  endtask

  task automatic test_sub_hold();
    logic [31:0] rr; logic zz, oo, ee;
    run(32'd5, 32'd5, 3'b010, 10, "sub_hold", rr, zz, oo, ee);
    checks++;
    if (rr !== 32'd0 || zz !== 1'b1) begin errors++; $display("FAIL sub_hold_const got r=%h z=%b want 0 1", rr, zz); end
  endtask

  task automatic test_slt_illegal();
    logic [31:0] rr; logic zz, oo, ee;
    run(32'hFFFFFFFF, 32'h00000001, 3'b101, 0, "slt", rr, zz, oo, ee);
    checks++;
    if (rr !== 32'd1) begin errors++; $display("FAIL slt_const got %h want 1", rr); end
    run(32'h00000001, 32'hFFFFFFFF, 3'b101, 0, "slt_neg", rr, zz, oo, ee);
    run(32'hFFFFFFFF, 32'h00000001, 3'b111, 0, "illegal7", rr, zz, oo, ee);
    checks++;
    if (rr !== 32'd0 || ee !== 1'b1 || oo !== 1'b0) begin
      errors++; $display("FAIL illegal_const got r=%h e=%b o=%b want 0 1 0", rr, ee, oo);
    end
    run(32'd9, 32'd9, 3'b110, 3, "illegal6_zero", rr, zz, oo, ee);
  endtask

  task automatic test_random();
    logic [31:0] rr; logic zz, oo, ee;
    for (int i = 0; i < 12; i++)
      run($urandom, (i % 4 == 0) ? 32'h0 : $urandom, 3'($urandom_range(0, 7)), i % 3, "random", rr, zz, oo, ee);
  endtask

  task automatic test_abort();
    logic [31:0] rr; logic zz, oo, ee;
    bit seen;
    @(negedge clk);
    a = 32'h12345678; b = 32'h9ABCDEF1; c = 3'b001; v = 1;
    @(negedge clk);
    v = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    checks++;
    if (ov !== 0 || r !== 0 || z !== 0 || o !== 0 || e !== 0 || ir !== 1) begin
      errors++; $display("FAIL abort_outputs got v=%b r=%h z=%b o=%b e=%b rdy=%b want zeros rdy=1", ov, r, z, o, e, ir);
    end
    seen = 0;
    repeat (40) begin @(negedge clk); if (ov) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_no_valid got 1 want 0"); end
    run(32'd2, 32'd3, 3'b000, 0, "after_abort", rr, zz, oo, ee);
    checks++;
    if (rr !== 32'd5) begin errors++; $display("FAIL after_abort_const got %h want 5", rr); end
  endtask

  task automatic test_width8();
    logic [31:0] rr; logic zz, oo, ee;
    sel = 1;
    run(32'h0F, 32'h11, 3'b001, 0, "w8_mul", rr, zz, oo, ee);
    checks++;
    if (rr !== 32'hFF) begin errors++; $display("FAIL w8_mul_const got %h want ff", rr); end
    run(32'hFF, 32'h01, 3'b000, 0, "w8_add", rr, zz, oo, ee);
    checks++;
    if (rr !== 32'h00 || oo !== 1'b0) begin errors++; $display("FAIL w8_add_const got r=%h o=%b want 0 0", rr, oo); end
    run(32'h7F, 32'h01, 3'b000, 0, "w8_add_ovf", rr, zz, oo, ee);
    run(32'h80, 32'h7F, 3'b101, 1, "w8_slt", rr, zz, oo, ee);
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_mul();
    test_sub_hold();
    test_slt_illegal();
    test_random();
    test_abort();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
